ex_mem_wb_stage: RTL and testbench

- Pipeline stage directly downstream of the 32-bit ALU in the five-stage MIPS datapath.
- Contains the EX/MEM pipeline register, which captures ALU result, store data and control.
- Contains the byte-addressable data memory, supporting lw/lh/lb/sw/sh/sb.
- Contains the MEM/WB pipeline register, which feeds register-file writeback.
- Exposes MEM-stage destination info so the forwarding unit can route results back to ALU operands.

---
 rtl/ex_mem_wb_stage.sv | 204 ++++++++++++++++++++
 tb/tb_ex_mem_wb_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_stage.sv
// EX/MEM pipeline register, byte-addressable data memory and MEM/WB pipeline
// register for the five-stage MIPS datapath. MEM-stage destination info is
// exported for the forwarding unit.
module ex_mem_wb_stage #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] EX_ALUResult,
   input  logic [31:0] EX_WriteData,
   input  logic [4:0]  EX_RegDst,
   input  logic        EX_RegWrite,
   input  logic        EX_MemRead,
   input  logic        EX_MemWrite,
   input  logic        EX_MemToReg,
   input  logic [1:0]  EX_MemSize,
   output logic [31:0] MEM_ALUResult,
   output logic [4:0]  MEM_RegDst,
   output logic        MEM_RegWrite,
   output logic [31:0] WB_Data,
   output logic [4:0]  WB_RegDst,
   output logic        WB_RegWrite,
   output logic        WB_AlignErr
);

   localparam int unsigned IW = $clog2(MEM_WORDS);

   // EX/MEM register fields
   logic [31:0] exm_alu_q,      exm_alu_d;
   logic [31:0] exm_wdata_q,    exm_wdata_d;
   logic [4:0]  exm_regdst_q,   exm_regdst_d;
   logic        exm_regwrite_q, exm_regwrite_d;
   logic        exm_memread_q,  exm_memread_d;
   logic        exm_memwrite_q, exm_memwrite_d;
   logic        exm_memtoreg_q, exm_memtoreg_d;
   logic [1:0]  exm_size_q,     exm_size_d;

   // MEM/WB register fields
   logic [31:0] wb_data_q,      wb_data_d;
   logic [4:0]  wb_regdst_q,    wb_regdst_d;
   logic        wb_regwrite_q,  wb_regwrite_d;
   logic        wb_alignerr_q,  wb_alignerr_d;

   // Data memory, one 32-bit word per entry, contents not reset
   logic [31:0] mem_q [MEM_WORDS];

   // MEM-stage datapath signals
   logic [IW-1:0] mem_idx;
   logic [1:0]    lane;
   logic          is_word;
   logic          is_half;
   logic          is_byte;
   logic          align_err;
   logic [31:0]   rd_word;
   logic [15:0]   rd_half;
   logic [7:0]    rd_byte;
   logic [31:0]   load_data;
   logic [3:0]    byte_en;
   logic [31:0]   st_data;
   logic [31:0]   wr_word;
   logic          mem_we;
   logic          addr_hi_unused;

   // Address decode, alignment check, load extraction and store lane merge
   always_comb begin
      mem_idx   = exm_alu_q[IW+1:2];
      lane      = exm_alu_q[1:0];
      is_half   = (exm_size_q == 2'b01);
      is_byte   = (exm_size_q == 2'b10);
      is_word   = !is_half && !is_byte;
      align_err = (exm_memread_q || exm_memwrite_q) &&
                  ((is_word && (lane != 2'b00)) || (is_half && lane[0]));

      rd_word = mem_q[mem_idx];
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (lane)
         2'b00:   rd_byte = rd_word[7:0];
         2'b01:   rd_byte = rd_word[15:8];
         2'b10:   rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase

      if (align_err) begin
         load_data = '0;
      end else if (is_byte) begin
         load_data = {{24{rd_byte[7]}}, rd_byte};
      end else if (is_half) begin
         load_data = {{16{rd_half[15]}}, rd_half};
      end else begin
         load_data = rd_word;
      end

      // Store data is replicated across lanes; byte_en picks the target lane(s)
      if (is_byte) begin
         st_data = {4{exm_wdata_q[7:0]}};
         case (lane)
            2'b00:   byte_en = 4'b0001;
            2'b01:   byte_en = 4'b0010;
            2'b10:   byte_en = 4'b0100;
            default: byte_en = 4'b1000;
         endcase
      end else if (is_half) begin
         st_data = {2{exm_wdata_q[15:0]}};
         byte_en = lane[1] ? 4'b1100 : 4'b0011;
      end else begin
         st_data = exm_wdata_q;
         byte_en = 4'b1111;
      end

      wr_word = rd_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (byte_en[i]) begin
            wr_word[8*i +: 8] = st_data[8*i +: 8];
         end
      end

      mem_we = Rst_n && !Stall && exm_memwrite_q && !align_err;
   end

   // Address bits above the word index alias onto the same memory words
   assign addr_hi_unused = ^exm_alu_q[31:IW+2];

   // Next-state for both pipeline registers: hold on stall, bubble on flush
   always_comb begin
      exm_alu_d      = exm_alu_q;
      exm_wdata_d    = exm_wdata_q;
      exm_regdst_d   = exm_regdst_q;
      exm_regwrite_d = exm_regwrite_q;
      exm_memread_d  = exm_memread_q;
      exm_memwrite_d = exm_memwrite_q;
      exm_memtoreg_d = exm_memtoreg_q;
      exm_size_d     = exm_size_q;
      wb_data_d      = wb_data_q;
      wb_regdst_d    = wb_regdst_q;
      wb_regwrite_d  = wb_regwrite_q;
      wb_alignerr_d  = wb_alignerr_q;

      if (!Stall) begin
         exm_alu_d      = EX_ALUResult;
         exm_wdata_d    = EX_WriteData;
         exm_regdst_d   = EX_RegDst;
         exm_memtoreg_d = EX_MemToReg;
         exm_size_d     = EX_MemSize;
         exm_regwrite_d = EX_RegWrite && !Flush;
         exm_memread_d  = EX_MemRead  && !Flush;
         exm_memwrite_d = EX_MemWrite && !Flush;

         wb_data_d      = exm_memtoreg_q ? load_data : exm_alu_q;
         wb_regdst_d    = exm_regdst_q;
         wb_regwrite_d  = exm_regwrite_q && !align_err;
         wb_alignerr_d  = align_err;
      end
   end

   // Pipeline register state with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         exm_alu_q      <= '0;
         exm_wdata_q    <= '0;
         exm_regdst_q   <= '0;
         exm_regwrite_q <= 1'b0;
         exm_memread_q  <= 1'b0;
         exm_memwrite_q <= 1'b0;
         exm_memtoreg_q <= 1'b0;
         exm_size_q     <= '0;
         wb_data_q      <= '0;
         wb_regdst_q    <= '0;
         wb_regwrite_q  <= 1'b0;
         wb_alignerr_q  <= 1'b0;
      end else begin
         exm_alu_q      <= exm_alu_d;
         exm_wdata_q    <= exm_wdata_d;
         exm_regdst_q   <= exm_regdst_d;
         exm_regwrite_q <= exm_regwrite_d;
         exm_memread_q  <= exm_memread_d;
         exm_memwrite_q <= exm_memwrite_d;
         exm_memtoreg_q <= exm_memtoreg_d;
         exm_size_q     <= exm_size_d;
         wb_data_q      <= wb_data_d;
         wb_regdst_q    <= wb_regdst_d;
         wb_regwrite_q  <= wb_regwrite_d;
         wb_alignerr_q  <= wb_alignerr_d;
      end
   end

   // Store commit as the instruction leaves EX/MEM; the load in the same
   // cycle already sampled the pre-store word combinationally
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem_q[mem_idx] <= wr_word;
      end
   end

   assign MEM_ALUResult = exm_alu_q;
   assign MEM_RegDst    = exm_regdst_q;
   assign MEM_RegWrite  = exm_regwrite_q && !(exm_memread_q && align_err);
   assign WB_Data       = wb_data_q;
   assign WB_RegDst     = wb_regdst_q;
   assign WB_RegWrite   = wb_regwrite_q;
   assign WB_AlignErr   = wb_alignerr_q;

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Bench for ex_mem_wb_stage: directed scenarios plus randomized traffic
// compared against a byte-array transaction model.
module tb_ex_mem_wb_stage;

   localparam int unsigned MW = 1024;
   localparam int unsigned MB = MW * 4;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic [31:0] EX_ALUResult = '0;
   logic [31:0] EX_WriteData = '0;
   logic [4:0]  EX_RegDst = '0;
   logic        EX_RegWrite = 1'b0;
   logic        EX_MemRead = 1'b0;
   logic        EX_MemWrite = 1'b0;
   logic        EX_MemToReg = 1'b0;
   logic [1:0]  EX_MemSize = '0;
   logic [31:0] MEM_ALUResult;
   logic [4:0]  MEM_RegDst;
   logic        MEM_RegWrite;
   logic [31:0] WB_Data;
   logic [4:0]  WB_RegDst;
   logic        WB_RegWrite;
   logic        WB_AlignErr;

   ex_mem_wb_stage #(.MEM_WORDS(MW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
      .EX_ALUResult(EX_ALUResult), .EX_WriteData(EX_WriteData),
      .EX_RegDst(EX_RegDst), .EX_RegWrite(EX_RegWrite),
      .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
      .EX_MemToReg(EX_MemToReg), .EX_MemSize(EX_MemSize),
      .MEM_ALUResult(MEM_ALUResult), .MEM_RegDst(MEM_RegDst),
      .MEM_RegWrite(MEM_RegWrite), .WB_Data(WB_Data),
      .WB_RegDst(WB_RegDst), .WB_RegWrite(WB_RegWrite),
      .WB_AlignErr(WB_AlignErr)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        m2r;
      logic [1:0]  sz;
   } ins_t;

   // Model: instruction held in EX/MEM, writeback results, byte memory
   ins_t        m_ex;
   bit          m_ex_dc;
   logic [31:0] m_wb_data;
   logic [4:0]  m_wb_rd;
   logic        m_wb_rw;
   logic        m_wb_err;
   bit          m_wb_dc;
   logic [7:0]  mb [MB];

   int n_checks = 0;
   int n_pass = 0;

   function automatic int unsigned nbytes(input logic [1:0] sz);
      case (sz)
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic misal(input ins_t i);
      int unsigned b;
      b = i.alu % MB;
      return (i.mr || i.mw) && ((b % nbytes(i.sz)) != 0);
   endfunction

   function automatic logic [31:0] ld_val(input ins_t i);
      int unsigned b, n;
      logic [31:0] v;
      if (misal(i)) return '0;
      n = nbytes(i.sz);
      b = i.alu % MB;
      v = 0;
      for (int k = int'(n) - 1; k >= 0; k--) v = (v << 8) + 32'(mb[b + k]);
      if (n == 1 && v >= 128) v = v - 256;
      if (n == 2 && v >= 32768) v = v - 65536;
      return v;
   endfunction

   function automatic logic [31:0] mword(input int unsigned idx);
      return {mb[4*idx+3], mb[4*idx+2], mb[4*idx+1], mb[4*idx]};
   endfunction

   function automatic logic [76:0] exp_vec();
      return {m_ex.alu, m_ex.rd, m_ex.rw && !(m_ex.mr && misal(m_ex)),
              m_wb_data, m_wb_rd, m_wb_rw, m_wb_err};
   endfunction

   function automatic logic [76:0] mask_vec();
      return {{37{!m_ex_dc}}, 1'b1, {37{!m_wb_dc}}, 2'b11};
   endfunction

   function automatic ins_t nop();
      ins_t i;
      i = '0;
      return i;
   endfunction

   function automatic ins_t mk_alu(input logic [31:0] v, input logic [4:0] rd);
      ins_t i;
      i = '0; i.alu = v; i.rd = rd; i.rw = 1'b1;
      return i;
   endfunction

   function automatic ins_t mk_ld(input logic [31:0] a, input logic [1:0] sz, input logic [4:0] rd);
      ins_t i;
      i = '0; i.alu = a; i.sz = sz; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1;
      return i;
   endfunction

   function automatic ins_t mk_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      ins_t i;
      i = '0; i.alu = a; i.wd = d; i.sz = sz; i.mw = 1'b1; i.rd = 5'(a);
      return i;
   endfunction

   function automatic ins_t rand_any();
      ins_t i;
      i = {$urandom, $urandom, 5'($urandom), 4'($urandom), 2'($urandom)};
      return i;
   endfunction

   task automatic model_edge(input ins_t in, input logic rst_n, input logic stall, input logic flush);
      logic e;
      logic [31:0] ld;
      int unsigned b;
      if (!rst_n) begin
         m_ex = '0; m_ex_dc = 0;
         m_wb_data = '0; m_wb_rd = '0; m_wb_rw = 1'b0; m_wb_err = 1'b0; m_wb_dc = 0;
      end else if (!stall) begin
         e  = misal(m_ex);
         ld = ld_val(m_ex);
         if (m_ex.mw && !e) begin
            b = m_ex.alu % MB;
            for (int unsigned k = 0; k < nbytes(m_ex.sz); k++)
               mb[b + k] = 8'((m_ex.wd >> (8 * k)) & 32'hFF);
         end
         m_wb_data = m_ex.m2r ? ld : m_ex.alu;
         m_wb_rd   = m_ex.rd;
         m_wb_rw   = m_ex.rw && !e;
         m_wb_err  = e;
         m_wb_dc   = m_ex_dc;
         m_ex      = in;
         m_ex_dc   = 0;
         if (flush) begin
            m_ex.rw = 1'b0; m_ex.mr = 1'b0; m_ex.mw = 1'b0; m_ex_dc = 1;
         end
      end
   endtask

   task automatic cycle(input ins_t in, input logic rst_n, input logic stall, input logic flush);
      EX_ALUResult = in.alu; EX_WriteData = in.wd; EX_RegDst = in.rd;
      EX_RegWrite = in.rw; EX_MemRead = in.mr; EX_MemWrite = in.mw;
      EX_MemToReg = in.m2r; EX_MemSize = in.sz;
      Rst_n = rst_n; Stall = stall; Flush = flush;
      @(posedge Clk);
      model_edge(in, rst_n, stall, flush);
      #1;
   endtask

   task automatic test_reset();
      logic [76:0] obs;
      for (int r = 0; r < 2; r++) begin
         cycle(rand_any(), 1'b0, 1'($urandom), 1'($urandom));
         obs = {MEM_ALUResult, MEM_RegDst, MEM_RegWrite, WB_Data, WB_RegDst, WB_RegWrite, WB_AlignErr};
         n_checks++;
         if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
         else n_pass++;
      end
      cycle(mk_alu(32'h2A, 5'd5), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({MEM_ALUResult, MEM_RegDst, MEM_RegWrite} !== {32'h2A, 5'd5, 1'b1})
         $display("FAIL first_mem: got %h/%0d/%b expected 2a/5/1", MEM_ALUResult, MEM_RegDst, MEM_RegWrite);
      else n_pass++;
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({WB_Data, WB_RegDst, WB_RegWrite, WB_AlignErr} !== {32'h2A, 5'd5, 1'b1, 1'b0})
         $display("FAIL first_wb: got %h/%0d/%b/%b expected 2a/5/1/0", WB_Data, WB_RegDst, WB_RegWrite, WB_AlignErr);
      else n_pass++;
   endtask

   task automatic init_memory();
      for (int unsigned w = 0; w < 16; w++) cycle(mk_st(4 * w, $urandom, 2'b00), 1'b1, 1'b0, 1'b0);
      cycle(nop(), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_load_store();
      cycle(mk_st(32'h10, 32'h8001FF7F, 2'b00), 1'b1, 1'b0, 1'b0);
      cycle(mk_ld(32'h10, 2'b00, 5'd3), 1'b1, 1'b0, 1'b0);
      cycle(mk_ld(32'h10, 2'b10, 5'd4), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'h8001FF7F) $display("FAIL lw_10: got %h expected 8001ff7f", WB_Data); else n_pass++;
      cycle(mk_ld(32'h11, 2'b10, 5'd4), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'h0000007F) $display("FAIL lb_10: got %h expected 0000007f", WB_Data); else n_pass++;
      cycle(mk_ld(32'h12, 2'b01, 5'd4), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'hFFFFFFFF) $display("FAIL lb_11: got %h expected ffffffff", WB_Data); else n_pass++;
      cycle(mk_st(32'h13, 32'h000000AB, 2'b10), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'hFFFF8001) $display("FAIL lh_12: got %h expected ffff8001", WB_Data); else n_pass++;
      cycle(mk_ld(32'h10, 2'b00, 5'd3), 1'b1, 1'b0, 1'b0);
      cycle(mk_st(32'h10, 32'h00001234, 2'b01), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'hAB01FF7F) $display("FAIL sb_13: got %h expected ab01ff7f", WB_Data); else n_pass++;
      cycle(mk_ld(32'h10, 2'b00, 5'd3), 1'b1, 1'b0, 1'b0);
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'hAB011234) $display("FAIL sh_10: got %h expected ab011234", WB_Data); else n_pass++;
   endtask

   task automatic test_misaligned();
      cycle(mk_st(32'h20, 32'hCAFEF00D, 2'b00), 1'b1, 1'b0, 1'b0);
      cycle(mk_ld(32'h22, 2'b00, 5'd12), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (MEM_RegWrite !== 1'b0) $display("FAIL mis_mem_regwrite: got %b expected 0", MEM_RegWrite); else n_pass++;
      cycle(mk_st(32'h21, 32'h00005555, 2'b01), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({WB_AlignErr, WB_RegWrite, WB_Data} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL mis_lw: got err=%b rw=%b data=%h expected 1/0/0", WB_AlignErr, WB_RegWrite, WB_Data);
      else n_pass++;
      cycle(mk_ld(32'h20, 2'b00, 5'd13), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_AlignErr !== 1'b1) $display("FAIL mis_sh_flag: got %b expected 1", WB_AlignErr); else n_pass++;
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({WB_Data, WB_AlignErr} !== {32'hCAFEF00D, 1'b0})
         $display("FAIL mis_sh_nowrite: got %h err=%b expected cafef00d/0", WB_Data, WB_AlignErr);
      else n_pass++;
   endtask

   task automatic test_stall_flush();
      logic [31:0] old;
      cycle(mk_alu(32'h77, 5'd7), 1'b1, 1'b0, 1'b0);
      cycle(mk_st(32'h30, 32'hDEADBEEF, 2'b00), 1'b1, 1'b0, 1'b0);
      old = mword(12);
      for (int s = 0; s < 3; s++) begin
         cycle(rand_any(), 1'b1, 1'b1, 1'($urandom));
         n_checks++;
         if ({MEM_ALUResult, MEM_RegWrite, WB_Data, WB_RegDst, WB_RegWrite} !== {32'h30, 1'b0, 32'h77, 5'd7, 1'b1})
            $display("FAIL stall_hold: got %h/%b/%h/%0d/%b expected 30/0/77/7/1",
                     MEM_ALUResult, MEM_RegWrite, WB_Data, WB_RegDst, WB_RegWrite);
         else n_pass++;
         n_checks++;
         if (dut.mem_q[12] !== old) $display("FAIL stall_nowrite: got %h expected %h", dut.mem_q[12], old);
         else n_pass++;
      end
      cycle(mk_ld(32'h30, 2'b00, 5'd8), 1'b1, 1'b0, 1'b0);
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'hDEADBEEF) $display("FAIL stall_release: got %h expected deadbeef", WB_Data); else n_pass++;

      old = mword(13);
      cycle(mk_st(32'h34, 32'h0BADF00D, 2'b00), 1'b1, 1'b0, 1'b1);
      cycle(mk_alu(32'h55, 5'd9), 1'b1, 1'b0, 1'b1);
      n_checks++;
      if ({MEM_RegWrite, WB_RegWrite, WB_AlignErr} !== 3'b000)
         $display("FAIL flush_bubble: got mem_rw=%b wb_rw=%b err=%b expected 0/0/0", MEM_RegWrite, WB_RegWrite, WB_AlignErr);
      else n_pass++;
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (dut.mem_q[13] !== old) $display("FAIL flush_nostore: got %h expected %h", dut.mem_q[13], old);
      else n_pass++;

      cycle(mk_alu(32'h99, 5'd10), 1'b1, 1'b0, 1'b0);
      cycle(rand_any(), 1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({MEM_ALUResult, MEM_RegWrite} !== {32'h99, 1'b1})
         $display("FAIL flush_under_stall: got %h/%b expected 99/1", MEM_ALUResult, MEM_RegWrite);
      else n_pass++;
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({WB_Data, WB_RegWrite} !== {32'h99, 1'b1})
         $display("FAIL flush_under_stall_wb: got %h/%b expected 99/1", WB_Data, WB_RegWrite);
      else n_pass++;
   endtask

   task automatic test_wrap_reset();
      logic [76:0] obs;
      cycle(mk_st(MB + 8, 32'h5, 2'b00), 1'b1, 1'b0, 1'b0);
      cycle(mk_ld(32'h8, 2'b00, 5'd11), 1'b1, 1'b0, 1'b0);
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'h5) $display("FAIL wrap: got %h expected 5", WB_Data); else n_pass++;
      cycle(mk_st(32'h8, 32'h777, 2'b00), 1'b1, 1'b0, 1'b0);
      cycle(rand_any(), 1'b0, 1'b0, 1'b0);
      obs = {MEM_ALUResult, MEM_RegDst, MEM_RegWrite, WB_Data, WB_RegDst, WB_RegWrite, WB_AlignErr};
      n_checks++;
      if (obs !== '0) $display("FAIL midop_reset: got %h expected 0", obs); else n_pass++;
      cycle(mk_ld(32'h8, 2'b00, 5'd11), 1'b1, 1'b0, 1'b0);
      cycle(mk_ld(32'h10, 2'b00, 5'd12), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'h5) $display("FAIL reset_nowrite: got %h expected 5", WB_Data); else n_pass++;
      cycle(nop(), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (WB_Data !== 32'hAB011234) $display("FAIL reset_preserve: got %h expected ab011234", WB_Data); else n_pass++;
   endtask

   task automatic test_random();
      ins_t i;
      logic [76:0] obs, ex, mk;
      int unsigned kind;
      for (int c = 0; c < 600; c++) begin
         i = rand_any();
         kind = $urandom_range(0, 9);
         i.alu = 4 * $urandom_range(0, 15) + $urandom_range(0, 3) + MB * $urandom_range(0, 2);
         i.mr = 1'b0; i.mw = 1'b0; i.m2r = 1'b0;
         if (kind <= 2) begin
            i.alu = $urandom;
         end else if (kind <= 5) begin
            i.mr = 1'b1; i.m2r = 1'b1;
         end else if (kind <= 8) begin
            i.mw = 1'b1;
         end else begin
            i.mr = 1'b1; i.mw = 1'b1; i.m2r = 1'($urandom);
         end
         cycle(i, 1'b1, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10));
         obs = {MEM_ALUResult, MEM_RegDst, MEM_RegWrite, WB_Data, WB_RegDst, WB_RegWrite, WB_AlignErr};
         ex = exp_vec();
         mk = mask_vec();
         n_checks++;
         if ((obs & mk) !== (ex & mk))
            $display("FAIL random_cycle %0d: got %h expected %h (mask %h)", c, obs & mk, ex & mk, mk);
         else n_pass++;
      end
   endtask

   initial begin
      m_ex = '0; m_ex_dc = 0;
      m_wb_data = '0; m_wb_rd = '0; m_wb_rw = 1'b0; m_wb_err = 1'b0; m_wb_dc = 0;
      test_reset();
      init_memory();
      test_load_store();
      test_misaligned();
      test_stall_flush();
      test_wrap_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
